bitonic_s2: RTL

Second stage of the 8-input bitonic sorting network, registered and flow-controlled. Consumes the eight values produced by stage 1 (pairs alternately sorted descending/ascending) and merges them into two sorted 4-element groups: elements 1–4 descending, elements 5–8 ascending. The result is an 8-element bitonic sequence ready for stage 3. The block is a 2-deep pipeline, one compare-exchange layer per pipeline register, with valid/ready handshakes on both sides.

---
 rtl/bitonic_pkg.sv | 13 +
 rtl/bitonic_s2_if.sv | 23 ++
 rtl/bitonic_cx.sv | 21 ++
 rtl/bitonic_s2.sv | 83 ++++++++
 4 files changed

// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic sorting network stages.
package bitonic_pkg;

    localparam int DATA_W = 8;
    localparam int NUM_EL = 8;

    localparam bit CX_DESC = 1'b0;
    localparam bit CX_ASC  = 1'b1;

    // Element 1 of a frame lives at index 0.
    typedef logic [NUM_EL-1:0][DATA_W-1:0] frame_t;

endpackage

// File: rtl/bitonic_s2_if.sv
// Valid/ready frame bus for the stage-2 merge block, both directions plus frame counter.
interface bitonic_s2_if;
    import bitonic_pkg::*;

    logic       in_valid;
    logic       in_ready;
    frame_t     number_in;
    logic       out_valid;
    logic       out_ready;
    frame_t     number_out;
    logic [7:0] frame_cnt;

    modport slave (
        input  in_valid, number_in, out_ready,
        output in_ready, out_valid, number_out, frame_cnt
    );

    modport master (
        output in_valid, number_in, out_ready,
        input  in_ready, out_valid, number_out, frame_cnt
    );

endinterface

// File: rtl/bitonic_cx.sv
// Combinational compare-exchange cell; o_lo is the lower-index result.
module bitonic_cx
    import bitonic_pkg::*;
#(
    parameter bit DIR = CX_DESC,
    parameter int W   = DATA_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi
);

    logic w_swap;

    // Strict compare so equal values pass straight through.
    assign w_swap = (DIR == CX_DESC) ? (i_b > i_a) : (i_a > i_b);
    assign o_lo   = w_swap ? i_b : i_a;
    assign o_hi   = w_swap ? i_a : i_b;

endmodule

// File: rtl/bitonic_s2.sv
// Stage 2 of the 8-input bitonic sorter: two registered CX layers with valid/ready flow control.
module bitonic_s2
    import bitonic_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    bitonic_s2_if.slave   bus
);

    logic       w_a_en;
    logic       w_b_en;
    frame_t     w_l1;
    frame_t     w_l2;
    logic       r_a_valid;
    frame_t     r_a_data;
    logic       r_out_valid;
    frame_t     r_out_data;
    logic [7:0] r_frame_cnt;

    assign w_b_en = !r_out_valid || bus.out_ready;
    assign w_a_en = !r_a_valid || w_b_en;

    genvar k;
    // Layer 1: distance-2 exchanges, upper half descending, lower half ascending.
    for (k = 0; k < 2; k++) begin : g_l1
        bitonic_cx #(.DIR(CX_DESC)) u_desc (
            .i_a  (bus.number_in[k]),
            .i_b  (bus.number_in[k+2]),
            .o_lo (w_l1[k]),
            .o_hi (w_l1[k+2])
        );
        bitonic_cx #(.DIR(CX_ASC)) u_asc (
            .i_a  (bus.number_in[k+4]),
            .i_b  (bus.number_in[k+6]),
            .o_lo (w_l1[k+4]),
            .o_hi (w_l1[k+6])
        );
    end

    // Layer 2: distance-1 exchanges on the registered stage-A frame.
    for (k = 0; k < 2; k++) begin : g_l2
        bitonic_cx #(.DIR(CX_DESC)) u_desc (
            .i_a  (r_a_data[2*k]),
            .i_b  (r_a_data[2*k+1]),
            .o_lo (w_l2[2*k]),
            .o_hi (w_l2[2*k+1])
        );
        bitonic_cx #(.DIR(CX_ASC)) u_asc (
            .i_a  (r_a_data[2*k+4]),
            .i_b  (r_a_data[2*k+5]),
            .o_lo (w_l2[2*k+4]),
            .o_hi (w_l2[2*k+5])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_valid   <= 1'b0;
            r_a_data    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_frame_cnt <= 8'd0;
        end else begin
            if (w_a_en) begin
                r_a_valid <= bus.in_valid;
                r_a_data  <= w_l1;
            end
            if (w_b_en) begin
                r_out_valid <= r_a_valid;
                r_out_data  <= w_l2;
            end
            if (r_out_valid && bus.out_ready) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign bus.in_ready   = w_a_en;
    assign bus.out_valid  = r_out_valid;
    assign bus.number_out = r_out_data;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule
